fas_freq_analyzer: RTL and testbench

//  Receiving end of the FAS FFT output interface (fft_valid + fft_d0..fft_d15).

---
 rtl/fas_freq_analyzer.sv | 137 +++++++++++++
 tb/tb_fas_freq_analyzer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fas_freq_analyzer.sv
// Receiving end of the FAS FFT stage: captures a 16-bin frame, finds the bin with
// the largest re^2+im^2 (lowest index wins ties) and reports it with a done strobe.
module fas_freq_analyzer #(
  parameter int DW = 16,
  parameter int MW = 2 * DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [3:0]      freq,
  output logic [MW-1:0]   peak_mag,
  output logic            busy,
  output logic            overflow
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t          state, state_next;
  logic [2*DW-1:0] frame_in  [16];
  logic [2*DW-1:0] frame_buf [16];
  logic [2:0]      pair_cnt;
  logic [MW-1:0]   run_max;
  logic [3:0]      run_idx;
  logic [MW-1:0]   mag_even, mag_odd, cand_mag, max_next;
  logic [3:0]      cand_idx, idx_next;
  logic            accept;

  // Products are formed in MW bits so the worst case (-2^(DW-1))^2 * 2 cannot wrap.
  function automatic logic [MW-1:0] bin_mag(input logic [2*DW-1:0] w);
    logic signed [MW-1:0] re_x, im_x, re_sq, im_sq;
    re_x  = {{(MW-DW){w[2*DW-1]}}, w[2*DW-1:DW]};
    im_x  = {{(MW-DW){w[DW-1]}}, w[DW-1:0]};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

  assign frame_in[0]  = fft_d0;
  assign frame_in[1]  = fft_d1;
  assign frame_in[2]  = fft_d2;
  assign frame_in[3]  = fft_d3;
  assign frame_in[4]  = fft_d4;
  assign frame_in[5]  = fft_d5;
  assign frame_in[6]  = fft_d6;
  assign frame_in[7]  = fft_d7;
  assign frame_in[8]  = fft_d8;
  assign frame_in[9]  = fft_d9;
  assign frame_in[10] = fft_d10;
  assign frame_in[11] = fft_d11;
  assign frame_in[12] = fft_d12;
  assign frame_in[13] = fft_d13;
  assign frame_in[14] = fft_d14;
  assign frame_in[15] = fft_d15;

  assign accept   = fft_valid && (state != SCAN);
  assign busy     = (state == SCAN);
  assign done     = (state == REPORT);
  assign mag_even = bin_mag(frame_buf[{pair_cnt, 1'b0}]);
  assign mag_odd  = bin_mag(frame_buf[{pair_cnt, 1'b1}]);

  // Strict comparisons keep the lower bin on ties, inside the pair and across pairs.
  always_comb begin
    cand_mag = mag_even;
    cand_idx = {pair_cnt, 1'b0};
    max_next = run_max;
    idx_next = run_idx;
    if (mag_odd > mag_even) begin
      cand_mag = mag_odd;
      cand_idx = {pair_cnt, 1'b1};
    end
    if (cand_mag > run_max) begin
      max_next = cand_mag;
      idx_next = cand_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fft_valid) state_next = SCAN;
      SCAN:    if (pair_cnt == 3'd7) state_next = REPORT;
      REPORT:  state_next = fft_valid ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) frame_buf[i] <= '0;
      pair_cnt <= '0;
      run_max  <= '0;
      run_idx  <= '0;
      freq     <= '0;
      peak_mag <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 16; i++) frame_buf[i] <= frame_in[i];
        pair_cnt <= '0;
        run_max  <= '0;
        run_idx  <= '0;
      end else if (state == SCAN) begin
        pair_cnt <= pair_cnt + 3'd1;
        run_max  <= max_next;
        run_idx  <= idx_next;
        if (pair_cnt == 3'd7) begin
          freq     <= idx_next;
          peak_mag <= max_next;
        end
      end
      if (state == SCAN && fft_valid) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fas_freq_analyzer.sv
// Self-checking bench for fas_freq_analyzer: a frame-timeline reference model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_fas_freq_analyzer;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done;
  logic [3:0]  freq;
  logic [31:0] peak_mag;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Reference model state: edge index of the last accepted frame and its result
  int     edge_n = 0;
  int     acc_edge = -1;
  int     pend_idx = 0;
  longint pend_peak = 0;
  int     m_freq = 0;
  longint m_peak = 0;
  bit     m_ovf = 0;
  bit     m_done, m_busy;

  logic [31:0] fr [16];

  fas_freq_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .peak_mag(peak_mag), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Straight search over all 16 bins; first strictly larger magnitude wins.
  function automatic void refPeak(input logic [31:0] f [16], output int idx, output longint pk);
    longint re, im, m;
    idx = 0;
    pk  = 0;
    for (int i = 0; i < 16; i++) begin
      re = longint'($signed(f[i][31:16]));
      im = longint'($signed(f[i][15:0]));
      m  = re * re + im * im;
      if (m > pk) begin
        pk  = m;
        idx = i;
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    edge_n++;
    if (rst) begin
      acc_edge = -1;
      m_freq   = 0;
      m_peak   = 0;
      m_ovf    = 0;
    end else if (fft_valid) begin
      if (acc_edge >= 0 && edge_n - acc_edge >= 1 && edge_n - acc_edge <= 8)
        m_ovf = 1;
      else begin
        acc_edge = edge_n;
        refPeak(d, pend_idx, pend_peak);
      end
    end
    m_done = !rst && acc_edge >= 0 && (edge_n - acc_edge == 8);
    m_busy = !rst && acc_edge >= 0 && (edge_n - acc_edge <= 7);
    if (m_done) begin
      m_freq = pend_idx;
      m_peak = pend_peak;
    end
    checkOutput("done", done, m_done);
    checkOutput("busy", busy, m_busy);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("freq", freq, m_freq);
    checkOutput("peak_mag", peak_mag, m_peak);
    if (done) done_seen++;
  end

  task automatic applyStimulus(input logic [31:0] f [16]);
    @(negedge clk);
    for (int i = 0; i < 16; i++) d[i] = f[i];
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
  endtask

  task automatic fillFrame(input logic [31:0] v);
    for (int i = 0; i < 16; i++) fr[i] = v;
  endtask

  // Sends fr, waits (bounded) for done and checks latency and literal results.
  task automatic runFrameExpect(input string name, input int exp_freq, input longint exp_peak);
    int lat;
    bit seen;
    lat  = 1;
    seen = 0;
    applyStimulus(fr);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #2;
      lat++;
      if (done) seen = 1;
    end
    checkOutput({name, "_latency"}, seen ? lat : -1, 9);
    checkOutput({name, "_freq"}, freq, exp_freq);
    checkOutput({name, "_peak"}, peak_mag, exp_peak);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, p;
    rst = 1'b1;
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_freq", freq, 0);
    checkOutput("reset_peak", peak_mag, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ovf", overflow, 0);
    rst = 1'b0;
    base = done_seen;
    repeat (20) @(negedge clk);
    checkOutput("idle_no_done", done_seen - base, 0);

    fillFrame(32'h0);
    fr[5] = {16'h0100, 16'h0000};
    runFrameExpect("single_bin5", 5, 64'h0001_0000);

    fillFrame({16'h0001, 16'h0001});
    fr[3]  = {16'h0040, 16'hFFC0};
    fr[11] = {16'h0040, 16'hFFC0};
    runFrameExpect("tie_3_11", 3, 64'h0000_2000);

    fillFrame(32'h0);
    fr[6] = {16'h0010, 16'h0010};
    fr[7] = {16'h0010, 16'hFFF0};
    runFrameExpect("tie_6_7", 6, 64'h0000_0200);

    fillFrame(32'h0);
    fr[15] = {16'h8000, 16'h8000};
    runFrameExpect("max_bin15", 15, 64'h8000_0000);

    fillFrame(32'h0);
    runFrameExpect("all_zero", 0, 0);

    // Back-to-back frames at the 16-cycle period, peak walking through every bin
    repeat (4) @(negedge clk);
    base = done_seen;
    for (int k = 0; k < 64; k++) begin
      p = k % 16;
      for (int i = 0; i < 16; i++)
        fr[i] = {16'($urandom_range(0, 255)), 16'($urandom_range(0, 255))};
      fr[p] = {16'(16'h1000 + $urandom_range(0, 255)), 16'($urandom_range(0, 255))};
      applyStimulus(fr);
      repeat (8) @(posedge clk);
      #2;
      checkOutput("burst_done", done, 1);
      checkOutput("burst_freq", freq, p);
      repeat (7) @(posedge clk);
    end
    repeat (4) @(negedge clk);
    checkOutput("burst_done_count", done_seen - base, 64);
    checkOutput("burst_ovf", overflow, 0);

    // A frame presented in the REPORT cycle is taken, not dropped
    base = done_seen;
    fillFrame(32'h0);
    fr[2] = {16'h0200, 16'h0000};
    applyStimulus(fr);
    repeat (7) @(negedge clk);
    fillFrame(32'h0);
    fr[9] = {16'h0300, 16'h0000};
    applyStimulus(fr);
    repeat (12) @(negedge clk);
    checkOutput("report_accept_count", done_seen - base, 2);
    checkOutput("report_accept_freq", freq, 9);
    checkOutput("report_accept_ovf", overflow, 0);

    // Randomized frames and gaps, including collisions with a running scan
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 16; i++) fr[i] = $urandom;
      applyStimulus(fr);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    // Second frame four cycles after the first is dropped and flags overflow
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = done_seen;
    fillFrame(32'h0);
    fr[4] = {16'h0100, 16'h0000};
    applyStimulus(fr);
    repeat (2) @(negedge clk);
    fillFrame(32'h0);
    fr[12] = {16'h0400, 16'h0000};
    applyStimulus(fr);
    repeat (12) @(negedge clk);
    checkOutput("drop_done_count", done_seen - base, 1);
    checkOutput("drop_freq", freq, 4);
    checkOutput("drop_ovf", overflow, 1);

    // Reset in the fifth scan cycle discards the frame entirely
    base = done_seen;
    fillFrame(32'h0);
    fr[8] = {16'h0100, 16'h0100};
    applyStimulus(fr);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midscan_rst_freq", freq, 0);
    checkOutput("midscan_rst_peak", peak_mag, 0);
    checkOutput("midscan_rst_ovf", overflow, 0);
    repeat (12) @(negedge clk);
    checkOutput("midscan_rst_no_done", done_seen - base, 0);

    fillFrame(32'h0);
    fr[10] = {16'hFF00, 16'h0000};
    runFrameExpect("after_rst", 10, 64'h0001_0000);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
